synth_param_bank: RTL and testbench

Parametrised parameter store for the synthesizer: a bank of NUM_MODULES × NUM_PARAMS value registers, each with a programmable upper limit, written from the switch panel and nudged up/down from the keyboard with saturation. It also owns the global octave counter, sampling the keyboard synchronously rather than clocking on key strobes. It sits between the switch/keyboard front end and the oscillator/ADSR consumers. It exposes a registered readback port and a change-notify pulse.

---
 rtl/synth_param_bank.sv | 84 ++++++++
 tb/tb_synth_param_bank.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/synth_param_bank.sv
// synth_param_bank: value/limit parameter bank with saturating key nudges, octave counter and registered readback.
module synth_param_bank #(
    parameter int NUM_MODULES   = 4,
    parameter int NUM_PARAMS    = 16,
    parameter int DATA_W        = 11,
    parameter int DEFAULT_VALUE = 0,
    parameter int OCT_MAX       = 6,
    parameter int OCT_DEFAULT   = 3,
    parameter int MOD_W         = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1,
    parameter int PAR_W         = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   lim_load,
    input  logic [MOD_W-1:0]       mod_sel,
    input  logic [PAR_W-1:0]       par_sel,
    input  logic [DATA_W-1:0]      wr_value,
    input  logic                   key_on,
    input  logic [7:0]             key_code,
    input  logic [MOD_W-1:0]       rd_mod,
    input  logic [PAR_W-1:0]       rd_par,
    output logic [DATA_W-1:0]      rd_data,
    output logic [2:0]             octave,
    output logic                   changed,
    output logic [MOD_W+PAR_W-1:0] changed_addr
);
    localparam logic [7:0] KEY_UP = 8'h75, KEY_DOWN = 8'h72, KEY_RIGHT = 8'h74, KEY_LEFT = 8'h6B;
    logic [DATA_W-1:0] values [NUM_MODULES][NUM_PARAMS];
    logic [DATA_W-1:0] limits [NUM_MODULES][NUM_PARAMS];
    logic              key_on_q;
    logic              key_event;
    logic              sel_ok;
    logic              rd_ok;
    logic              differs;
    logic [DATA_W-1:0] cur_value;
    logic [DATA_W-1:0] cur_limit;
    logic [DATA_W-1:0] next_value;
    logic [DATA_W-1:0] next_limit;
    assign key_event = key_on & ~key_on_q;
    assign sel_ok    = (int'(mod_sel) < NUM_MODULES) && (int'(par_sel) < NUM_PARAMS);
    assign rd_ok     = (int'(rd_mod) < NUM_MODULES) && (int'(rd_par) < NUM_PARAMS);
    assign cur_value = sel_ok ? values[mod_sel][par_sel] : '0;
    assign cur_limit = sel_ok ? limits[mod_sel][par_sel] : '0;
    assign differs   = sel_ok && (next_value != cur_value);
    // Writes win over a same-cycle key step; the step is simply dropped.
    always_comb begin
        next_limit = lim_load ? wr_value : cur_limit;
        next_value = (load && lim_load)                   ? wr_value :
                     load                                 ? ((wr_value > cur_limit) ? cur_limit : wr_value) :
                     lim_load                             ? ((cur_value > wr_value) ? wr_value : cur_value) :
                     (key_event && key_code == KEY_RIGHT) ? ((cur_value < cur_limit) ? cur_value + DATA_W'(1) : cur_value) :
                     (key_event && key_code == KEY_LEFT)  ? ((cur_value != '0) ? cur_value - DATA_W'(1) : cur_value) :
                                                            cur_value;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int m = 0; m < NUM_MODULES; m++)
                for (int p = 0; p < NUM_PARAMS; p++) begin
                    values[m][p] <= DATA_W'(DEFAULT_VALUE);
                    limits[m][p] <= '1;
                end
            octave       <= 3'(OCT_DEFAULT);
            rd_data      <= '0;
            changed      <= 1'b0;
            changed_addr <= '0;
            key_on_q     <= 1'b1;
        end else begin
            key_on_q <= key_on;
            if (sel_ok) begin
                values[mod_sel][par_sel] <= next_value;
                limits[mod_sel][par_sel] <= next_limit;
            end
            changed <= differs;
            if (differs)
                changed_addr <= {mod_sel, par_sel};
            rd_data <= rd_ok ? values[rd_mod][rd_par] : '0;
            if (key_event && key_code == KEY_UP && int'(octave) < OCT_MAX)
                octave <= octave + 3'd1;
            else if (key_event && key_code == KEY_DOWN && octave != 3'd0)
                octave <= octave - 3'd1;
        end
    end
endmodule

// File: tb/tb_synth_param_bank.sv
// tb_synth_param_bank: directed and random stimulus against an array-based reference of the parameter bank.
module tb_synth_param_bank;
    localparam int NM = 3, NP = 16, DW = 11, MW = 2, PW = 4;
    logic          clock = 1'b0;
    logic          reset, load, lim_load, key_on, changed;
    logic [MW-1:0] mod_sel, rd_mod;
    logic [PW-1:0] par_sel, rd_par;
    logic [DW-1:0] wr_value, rd_data;
    logic [7:0]    key_code;
    logic [2:0]    octave;
    logic [MW+PW-1:0] changed_addr;
    int mv [NM][NP];
    int ml [NM][NP];
    int moct, mchg, maddr, mrd;
    bit mkq;
    int n_checks = 0, n_fail = 0;
    int exp_up [7] = '{4, 5, 6, 6, 6, 6, 6};
    int exp_dn [7] = '{5, 4, 3, 2, 1, 0, 0};
    logic [7:0] codes [5] = '{8'h75, 8'h72, 8'h74, 8'h6B, 8'h10};

    always #5 clock = ~clock;

    synth_param_bank #(.NUM_MODULES(NM), .NUM_PARAMS(NP), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .load(load), .lim_load(lim_load),
        .mod_sel(mod_sel), .par_sel(par_sel), .wr_value(wr_value),
        .key_on(key_on), .key_code(key_code), .rd_mod(rd_mod), .rd_par(rd_par),
        .rd_data(rd_data), .octave(octave), .changed(changed), .changed_addr(changed_addr)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Predict one clock edge from the current inputs, then compare all outputs.
    task automatic tick();
        int old_v, new_v, lim;
        bit ev;
        ev = key_on && !mkq;
        mrd = (int'(rd_mod) < NM) ? mv[rd_mod][rd_par] : 0;
        mchg = 0;
        if (int'(mod_sel) < NM) begin
            old_v = mv[mod_sel][par_sel];
            lim = ml[mod_sel][par_sel];
            new_v = old_v;
            if (load && lim_load) begin
                lim = wr_value;
                new_v = wr_value;
            end else if (load)
                new_v = (int'(wr_value) < lim) ? int'(wr_value) : lim;
            else if (lim_load) begin
                lim = wr_value;
                if (old_v > lim) new_v = lim;
            end else if (ev && key_code == 8'h74)
                new_v = (old_v < lim) ? old_v + 1 : lim;
            else if (ev && key_code == 8'h6B)
                new_v = (old_v > 0) ? old_v - 1 : 0;
            mv[mod_sel][par_sel] = new_v;
            ml[mod_sel][par_sel] = lim;
            if (new_v != old_v) begin
                mchg = 1;
                maddr = int'(mod_sel) * NP + int'(par_sel);
            end
        end
        if (ev && key_code == 8'h75 && moct < 6) moct++;
        else if (ev && key_code == 8'h72 && moct > 0) moct--;
        mkq = key_on;
        @(posedge clock);
        #1;
        check("rd_data", rd_data, mrd);
        check("changed", changed, mchg);
        check("changed_addr", changed_addr, maddr);
        check("octave", octave, moct);
    endtask

    task automatic do_reset();
        reset = 1; key_on = 1; load = 0; lim_load = 0;
        @(posedge clock);
        #1;
        reset = 0;
        for (int m = 0; m < NM; m++)
            for (int p = 0; p < NP; p++) begin
                mv[m][p] = 0;
                ml[m][p] = 2047;
            end
        moct = 3; mrd = 0; mchg = 0; maddr = 0; mkq = 1;
        check("rst_octave", octave, 3);
        check("rst_rd", rd_data, 0);
        check("rst_changed", changed, 0);
        check("rst_addr", changed_addr, 0);
    endtask

    task automatic press(input logic [7:0] code);
        key_on = 0;
        tick();
        key_code = code;
        key_on = 1;
        tick();
    endtask

    task automatic write(input bit ld, input bit ll, input int m, input int p, input int v);
        load = ld; lim_load = ll; mod_sel = MW'(m); par_sel = PW'(p); wr_value = DW'(v);
        tick();
        load = 0; lim_load = 0;
    endtask

    task automatic read(input int m, input int p);
        rd_mod = MW'(m); rd_par = PW'(p);
        tick();
        tick();
    endtask

    initial begin
        load = 0; lim_load = 0; mod_sel = 0; par_sel = 0; wr_value = 0;
        key_on = 1; key_code = 8'h75; rd_mod = 0; rd_par = 0; reset = 1;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        check("held_key_octave", octave, 3);
        press(8'h75);
        check("first_up", octave, 4);

        do_reset();
        for (int i = 0; i < 7; i++) begin
            press(8'h75);
            check("oct_up", octave, exp_up[i]);
        end
        for (int i = 0; i < 7; i++) begin
            press(8'h72);
            check("oct_down", octave, exp_dn[i]);
        end

        mod_sel = 1; par_sel = 2;
        write(0, 1, 1, 2, 5);
        write(1, 0, 1, 2, 9);
        read(1, 2);
        check("clamped_load", rd_data, 5);
        for (int i = 0; i < 3; i++) begin
            press(8'h74);
            check("sat_no_pulse", changed, 0);
        end
        press(8'h6B);
        check("left_pulse", changed, 1);
        check("left_addr", changed_addr, 'h12);
        read(1, 2);
        check("left_value", rd_data, 4);

        write(1, 0, 0, 3, 100);
        write(0, 1, 0, 3, 40);
        check("limit_clamp_pulse", changed, 1);
        read(0, 3);
        check("limit_clamp_value", rd_data, 40);
        key_on = 0;
        tick();
        key_code = 8'h74; key_on = 1;
        write(1, 0, 0, 3, 7);
        read(0, 3);
        check("load_beats_step", rd_data, 7);

        rd_mod = 2; rd_par = 0;
        tick();
        write(1, 0, 2, 0, 'h2AA);
        check("rd_old", rd_data, 0);
        tick();
        check("rd_new", rd_data, 'h2AA);

        write(1, 1, 3, 5, 55);
        check("oor_no_pulse", changed, 0);
        read(3, 5);
        check("oor_read", rd_data, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            load = ($urandom_range(0, 5) == 0);
            lim_load = ($urandom_range(0, 7) == 0);
            mod_sel = MW'($urandom_range(0, 3));
            par_sel = PW'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15));
            wr_value = DW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 2047) : $urandom_range(0, 40));
            if ($urandom_range(0, 1)) key_on = ~key_on;
            key_code = codes[$urandom_range(0, 4)];
            rd_mod = MW'($urandom_range(0, 3));
            rd_par = PW'($urandom_range(0, 3));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
